// File: rtl/aq_gemac_udp_txpack_if.sv
// ---------------------------------------------------------------------------
// aq_gemac_udp_txpack_if
//
// Send-side handshake between the UDP transmit packer and the UDP
// controller. One datagram is requested with a single-cycle pulse. Its
// payload is then read word by word with the controller's read strobe.
//
//   send_request     packer -> ctrl   one-cycle datagram request pulse
//   send_length[16]  packer -> ctrl   payload length in bytes
//   send_busy        ctrl -> packer   controller is handling a datagram
//   send_data_valid  packer -> ctrl   send_data holds a payload word
//   send_data_read   ctrl -> packer   controller consumes send_data
//   send_data[32]    packer -> ctrl   current payload word (show-ahead)
//
// master: the packer side. slave: the controller side.
// ---------------------------------------------------------------------------
interface aq_gemac_udp_txpack_if;
    logic        send_request;
    logic [15:0] send_length;
    logic        send_busy;
    logic        send_data_valid;
    logic        send_data_read;
    logic [31:0] send_data;

    modport master (
        output send_request,
        output send_length,
        output send_data_valid,
        output send_data,
        input  send_busy,
        input  send_data_read
    );

    modport slave (
        input  send_request,
        input  send_length,
        input  send_data_valid,
        input  send_data,
        output send_busy,
        output send_data_read
    );
endinterface

// File: rtl/aq_gemac_udp_txpack.sv
// ---------------------------------------------------------------------------
// aq_gemac_udp_txpack
//
// Buffers a 32-bit user word stream in a show-ahead FIFO and cuts it into
// UDP datagrams of pkt_words words, clamped to 1..2^DEPTH_LOG2. The flush
// input sends out a short datagram holding whatever words are buffered.
//
// Ports
//   clk, rst        system clock and synchronous active-high reset
//   din_valid/din   user word stream; din[31:24] is sent first
//   din_ready       FIFO can accept a word (fifo_count < depth)
//   pkt_words       payload words per datagram, sampled at request time
//   flush           level; send the residual words as a short datagram
//   send            controller send interface (master side)
//   fifo_count      words currently buffered
//   pkt_count       datagrams completed, wraps at 16 bits
// ---------------------------------------------------------------------------
module aq_gemac_udp_txpack #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_valid,
    input  logic [31:0]             din,
    output logic                    din_ready,
    input  logic [DEPTH_LOG2:0]     pkt_words,
    input  logic                    flush,
    aq_gemac_udp_txpack_if.master   send,
    output logic [DEPTH_LOG2:0]     fifo_count,
    output logic [15:0]             pkt_count
);

    localparam logic [DEPTH_LOG2:0]   DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_XFER,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]           mem [0:(1 << DEPTH_LOG2) - 1];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   rem_q;
    logic [15:0]           len_q;
    logic [15:0]           pkt_count_q;
    logic [31:0]           data_q;
    logic                  nonempty_q;

    logic [DEPTH_LOG2:0]   n_eff;
    logic [DEPTH_LOG2:0]   len_words;
    logic                  start_full, start_flush;
    logic                  req, valid;
    logic                  wr_en, pop;

    // -----------------------------------------------------------------------
    // Datagram sizing and start conditions
    // -----------------------------------------------------------------------
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        n_eff = pkt_words;
        if (pkt_words == '0) begin
            n_eff = CNT_ONE;
        end else if (pkt_words > DEPTH) begin
            n_eff = DEPTH;
        end
    end

    assign start_full  = (count_q >= n_eff);
    assign start_flush = flush && (count_q != '0) && (count_q < n_eff);
    assign len_words   = start_full ? n_eff : count_q;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever order the processes run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (!send.send_busy && (start_full || start_flush)) state_d = ST_REQ;
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: if (send.send_busy) state_d = ST_XFER;
            // The pop that consumes the last word of the datagram ends XFER.
            ST_XFER: if (pop && (rem_q == CNT_ONE)) state_d = ST_DONE;
            ST_DONE: if (!send.send_busy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        req   = (state_q == ST_REQ);
        valid = (state_q == ST_XFER) && (rem_q != '0);
    end

    // A read strobe without valid data is ignored.
    assign pop   = send.send_data_read && valid;
    assign wr_en = din_valid && din_ready;

    // -----------------------------------------------------------------------
    // FIFO storage
    // -----------------------------------------------------------------------
    // NOTE: the storage array has no reset. The pointers and count define
    // which entries are live, so clearing the array would only cost logic
    // and keep it out of block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers, datagram bookkeeping and show-ahead output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rem_q       <= '0;
            len_q       <= '0;
            pkt_count_q <= '0;
            data_q      <= '0;
            nonempty_q  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;

            unique case ({wr_en, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase

            // The datagram size is frozen when the request is committed. Words
            // written afterwards wait for the next datagram.
            if (state_q == ST_IDLE && state_d == ST_REQ) begin
                rem_q <= len_words;
                len_q <= 16'({len_words, 2'b00});
            end else if (pop) begin
                rem_q <= rem_q - CNT_ONE;
            end

            if (state_q == ST_DONE && state_d == ST_IDLE) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end

            // The head register follows the FIFO head one cycle late. On a pop
            // it jumps straight to the following entry, which is always at
            // least one cycle old, so back-to-back reads see no bubble. A word
            // written into an empty FIFO waits one extra cycle (nonempty_q)
            // before it is shown.
            nonempty_q <= (count_q != '0);
            if (pop) begin
                if (count_q > CNT_ONE) data_q <= mem[rd_ptr_q + PTR_ONE];
            end else if (nonempty_q && (count_q != '0)) begin
                data_q <= mem[rd_ptr_q];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign din_ready            = (count_q < DEPTH);
    assign fifo_count           = count_q;
    assign pkt_count            = pkt_count_q;
    assign send.send_request    = req;
    assign send.send_length     = len_q;
    assign send.send_data_valid = valid;
    assign send.send_data       = data_q;

endmodule

// File: tb/tb_aq_gemac_udp_txpack.sv
// ---------------------------------------------------------------------------
// tb_aq_gemac_udp_txpack
//
// Self-checking bench for aq_gemac_udp_txpack at the default depth of 512.
// The reference model is a queue of every accepted word plus a 16-bit
// datagram counter. The bench plays the UDP controller. It expects each
// datagram to carry the next words of the queue in order, with the length
// given by the packetising rules.
// ---------------------------------------------------------------------------
module tb_aq_gemac_udp_txpack;

    localparam int DL2   = 9;
    localparam int DEPTH = 1 << DL2;

    logic           clk = 1'b0;
    logic           rst;
    logic           din_valid;
    logic [31:0]    din;
    logic           din_ready;
    logic [DL2:0]   pkt_words;
    logic           flush;
    logic [DL2:0]   fifo_count;
    logic [15:0]    pkt_count;

    aq_gemac_udp_txpack_if sif ();

    aq_gemac_udp_txpack #(.DEPTH_LOG2(DL2)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .pkt_words  (pkt_words),
        .flush      (flush),
        .send       (sif),
        .fifo_count (fifo_count),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_q [$];
    logic [15:0] exp_pkts = 16'd0;

    // ---------------------------------------------------------------------
    // Stimulus helpers. Inputs change and outputs are sampled on the
    // falling edge.
    // ---------------------------------------------------------------------
    task automatic write_words(input int n, input bit rnd, input logic [31:0] base,
                               input logic [31:0] step, input int max_cyc, output int sent);
        sent = 0;
        for (int cyc = 0; sent < n && cyc < max_cyc; cyc++) begin
            @(negedge clk);
            if (din_ready) begin
                din_valid = 1'b1;
                din       = rnd ? $urandom : base + step * sent;
                model_q.push_back(din);
                sent++;
            end else begin
                din_valid = 1'b0;
            end
        end
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    // Plays the controller for one datagram of exp_words words.
    task automatic serve(input int exp_words, input bit always_read);
        bit seen = 0;
        bit started = 0;
        int got = 0;
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
            @(negedge clk);
            if (sif.send_request) seen = 1;
            else sif.send_busy = 1'b0;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL req_timeout got no request exp len %0d", exp_words * 4);
            return;
        end
        checks++;
        if (sif.send_length !== 16'(exp_words * 4)) begin
            errors++;
            $display("FAIL send_length got %0d exp %0d", sif.send_length, exp_words * 4);
        end
        sif.send_busy = 1'b1;
        @(negedge clk);
        checks++;
        if (sif.send_request !== 1'b0) begin
            errors++;
            $display("FAIL req_pulse got %0b exp 0", sif.send_request);
        end
        for (int cyc = 0; cyc < exp_words * 8 + 50 && got < exp_words; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (sif.send_data_valid) begin
                started = 1;
                checks++;
                if (model_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word got %08h exp none", sif.send_data);
                end else if (sif.send_data !== model_q[0]) begin
                    errors++;
                    $display("FAIL send_data got %08h exp %08h", sif.send_data, model_q[0]);
                end
                if (always_read || $urandom_range(0, 3) != 0) begin
                    sif.send_data_read = 1'b1;
                    if (model_q.size() != 0) void'(model_q.pop_front());
                    got++;
                end else begin
                    sif.send_data_read = 1'b0;
                end
            end else begin
                if (started && always_read) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_gap got valid 0 exp 1 after %0d words", got);
                end
                // Stray read strobes while no word is valid must be ignored.
                sif.send_data_read = 1'($urandom_range(0, 1));
            end
        end
        checks++;
        if (got < exp_words) begin
            errors++;
            $display("FAIL xfer_timeout got %0d words exp %0d", got, exp_words);
        end
        @(negedge clk);
        checks++;
        if (sif.send_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_after_last got %0b exp 0", sif.send_data_valid);
        end
        sif.send_data_read = 1'b1;
        @(negedge clk);
        sif.send_data_read = 1'b0;
        sif.send_busy      = 1'b0;
        @(negedge clk);
        exp_pkts = exp_pkts + 16'd1;
        checks++;
        if (pkt_count !== exp_pkts) begin
            errors++;
            $display("FAIL pkt_count got %0d exp %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic check_fifo_empty(input string tag);
        checks++;
        if (fifo_count !== '0) begin
            errors++;
            $display("FAIL %s fifo_count got %0d exp 0", tag, fifo_count);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (din_ready !== 1'b1 || sif.send_request !== 1'b0 || sif.send_length !== 16'd0 ||
            sif.send_data_valid !== 1'b0 || sif.send_data !== 32'd0 ||
            fifo_count !== '0 || pkt_count !== 16'd0) begin
            errors++;
            $display("FAIL %s got rdy=%0b req=%0b len=%0h vld=%0b data=%08h cnt=%0d pkts=%0d exp 1 0 0 0 0 0 0",
                     tag, din_ready, sif.send_request, sif.send_length, sif.send_data_valid,
                     sif.send_data, fifo_count, pkt_count);
        end
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; din_valid = 1'b0; din = '0; pkt_words = '0; flush = 1'b0;
        sif.send_busy = 1'b0; sif.send_data_read = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        model_q.delete();
        exp_pkts = 16'd0;
        @(negedge clk);
        check_reset_outputs("after_reset");
    endtask

    task automatic test_basic();
        int sent;
        sif.send_busy = 1'b1;
        pkt_words = 10'd4;
        write_words(4, 0, 32'h1111_1111, 32'h1111_1111, 100, sent);
        checks++;
        if (fifo_count !== 10'd4) begin
            errors++;
            $display("FAIL basic_count got %0d exp 4", fifo_count);
        end
        serve(4, 1);
        check_fifo_empty("basic");
    endtask

    task automatic test_flush();
        int sent;
        int reqs = 0;
        sif.send_busy = 1'b1;
        pkt_words = 10'd8;
        write_words(3, 1, '0, '0, 100, sent);
        flush = 1'b1;
        serve(3, 0);
        flush = 1'b0;
        check_fifo_empty("flush");
        // A flush with nothing buffered must not request a datagram.
        flush = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (sif.send_request) reqs++;
        end
        flush = 1'b0;
        checks++;
        if (reqs != 0) begin
            errors++;
            $display("FAIL empty_flush got %0d requests exp 0", reqs);
        end
    endtask

    task automatic test_full();
        int sent;
        sif.send_busy = 1'b1;
        pkt_words = 10'(DEPTH);
        write_words(DEPTH + 8, 1, '0, '0, DEPTH + 8, sent);
        checks++;
        if (sent != DEPTH) begin
            errors++;
            $display("FAIL full_accepted got %0d exp %0d", sent, DEPTH);
        end
        checks++;
        if (din_ready !== 1'b0 || fifo_count !== 10'(DEPTH)) begin
            errors++;
            $display("FAIL full_state got rdy=%0b cnt=%0d exp rdy=0 cnt=%0d", din_ready, fifo_count, DEPTH);
        end
        serve(DEPTH, 0);
        check_fifo_empty("full");
    endtask

    task automatic test_clamp();
        int sent;
        sif.send_busy = 1'b1;
        pkt_words = 10'd0;
        write_words(2, 1, '0, '0, 100, sent);
        serve(1, 0);
        serve(1, 0);
        check_fifo_empty("clamp_zero");
        sif.send_busy = 1'b1;
        pkt_words = 10'd1023;
        write_words(DEPTH, 1, '0, '0, DEPTH + 100, sent);
        serve(DEPTH, 1);
        check_fifo_empty("clamp_high");
    endtask

    task automatic test_stream();
        int sent;
        pkt_words = 10'd256;
        fork
            write_words(1024, 0, 32'h0100_0000, 32'd1, 8000, sent);
            begin
                repeat (4) serve(256, 1);
            end
        join
        check_fifo_empty("stream");
    endtask

    task automatic test_random();
        int sent;
        int n_eff;
        for (int it = 0; it < 8; it++) begin
            sif.send_busy = 1'b1;
            pkt_words = 10'($urandom_range(0, 12));
            n_eff     = (pkt_words == 0) ? 1 : int'(pkt_words);
            write_words($urandom_range(1, 30), 1, '0, '0, 500, sent);
            while (model_q.size() >= n_eff) serve(n_eff, 0);
            if (model_q.size() > 0) begin
                flush = 1'b1;
                serve(model_q.size(), 0);
                flush = 1'b0;
            end
            check_fifo_empty("random");
        end
    endtask

    task automatic test_reset_mid();
        int sent;
        int got = 0;
        bit seen = 0;
        sif.send_busy = 1'b1;
        pkt_words = 10'd4;
        write_words(4, 1, '0, '0, 100, sent);
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            @(negedge clk);
            if (sif.send_request) seen = 1;
            else sif.send_busy = 1'b0;
        end
        sif.send_busy = 1'b1;
        for (int cyc = 0; cyc < 100 && got < 2; cyc++) begin
            @(negedge clk);
            if (sif.send_data_valid) begin
                checks++;
                if (sif.send_data !== model_q[0]) begin
                    errors++;
                    $display("FAIL mid_data got %08h exp %08h", sif.send_data, model_q[0]);
                end
                sif.send_data_read = 1'b1;
                void'(model_q.pop_front());
                got++;
            end else begin
                sif.send_data_read = 1'b0;
            end
        end
        @(negedge clk);
        rst = 1'b1;
        sif.send_data_read = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        sif.send_busy = 1'b0;
        model_q.delete();
        exp_pkts = 16'd0;
        // The packer must work normally straight after a mid-datagram reset.
        sif.send_busy = 1'b1;
        pkt_words = 10'd1;
        write_words(1, 1, '0, '0, 100, sent);
        serve(1, 0);
        check_fifo_empty("post_reset");
    endtask

    task automatic test_wrap();
        int sent;
        sif.send_busy = 1'b1;
        @(negedge clk);
        force dut.pkt_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.pkt_count_q;
        exp_pkts = 16'hFFFF;
        pkt_words = 10'd1;
        write_words(1, 1, '0, '0, 100, sent);
        serve(1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush();
        test_full();
        test_clamp();
        test_stream();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aq_gemac_udp_txpack.md
# aq_gemac_udp_txpack

UDP transmit packer that sits directly upstream of the UDP controller's send interface (SEND_REQUEST / SEND_LENGTH / SEND_BUSY / SEND_DATA_VALID / SEND_DATA_READ / SEND_DATA). It buffers a continuous 32-bit word stream from user logic in an internal FIFO and cuts it into UDP datagrams of a programmable word count. It issues one send request per datagram and supplies the payload words on the controller's read strobe. A flush input forces out a short final datagram.

## Interface
- DEPTH_LOG2, 9, FIFO depth is 2^DEPTH_LOG2 words (512 at default).
- CLK  in  1  system clock (SYS_CLK domain); all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- DIN_VALID  in  1  user word valid.
- DIN  in  32  user payload word; byte [31:24] is sent first.
- DIN_READY  out  1  FIFO can accept a word; a write occurs when DIN_VALID & DIN_READY.
- PKT_WORDS  in  DEPTH_LOG2+1  payload words per datagram; sampled when a request is issued.
- FLUSH  in  1  level; send the residual words as a short datagram.
- SEND_REQUEST  out  1  one-cycle datagram request pulse.
- SEND_LENGTH  out  16  payload length in bytes (words × 4).
- SEND_BUSY  in  1  controller busy with a datagram.
- SEND_DATA_VALID  out  1  SEND_DATA holds a valid word of the current datagram.
- SEND_DATA_READ  in  1  controller consumes SEND_DATA this cycle.
- SEND_DATA  out  32  current payload word (show-ahead).
- FIFO_COUNT  out  DEPTH_LOG2+1  words currently buffered.
- PKT_COUNT  out  16  datagrams completed; wraps 0xFFFF→0.

## Operation
- FIFO: show-ahead, depth D = 2^DEPTH_LOG2.
  - DIN_READY = (FIFO_COUNT < D).
  - Simultaneous write and pop leaves the count unchanged.
  - Pointers wrap modulo D.
- Effective size N = PKT_WORDS clamped to the range 1..D. A value of 0 is treated as 1; values above D are treated as D.
- IDLE:
  - If SEND_BUSY=0 and FIFO_COUNT ≥ N: latch rem = N and SEND_LENGTH = N×4, then go to REQ.
  - Else if SEND_BUSY=0, FLUSH=1 and 0 < FIFO_COUNT < N: latch rem = FIFO_COUNT and SEND_LENGTH = FIFO_COUNT×4, then go to REQ.
- REQ: assert SEND_REQUEST for exactly this one cycle, then go to WAIT.
- WAIT: stay until SEND_BUSY=1, then go to XFER.
- XFER:
  - SEND_DATA_VALID = (rem ≠ 0).
  - A pop occurs when SEND_DATA_READ & SEND_DATA_VALID. Each pop decrements rem and advances the FIFO head.
  - When rem reaches 0, go to DONE.
  - SEND_DATA_READ while SEND_DATA_VALID=0 is ignored: no pop, no error.
- DONE: stay until SEND_BUSY=0, then increment PKT_COUNT and go to IDLE.
- SEND_LENGTH is held stable from REQ until the return to IDLE.
- Writes are accepted in every state. Words written during XFER are never included in the current datagram beyond rem.
- FLUSH is ignored outside IDLE. It does not request anything when FIFO_COUNT=0.

## Timing
- Reset values: DIN_READY=1, SEND_REQUEST=0, SEND_LENGTH=0, SEND_DATA_VALID=0, SEND_DATA=0, FIFO_COUNT=0, PKT_COUNT=0, state IDLE.
- RST asserted mid-datagram discards all FIFO contents and the datagram in progress. Outputs return to reset values on the next edge.
- Write to FIFO_COUNT update: 1 cycle.
- A word written into an empty FIFO is visible on SEND_DATA no earlier than 2 cycles after the write edge.
- Request condition true in IDLE → SEND_REQUEST high on the next cycle.
- Pop: SEND_DATA presents the next word in the cycle after the read edge. Back-to-back reads every cycle are sustained without gaps while rem > 0.
- SEND_DATA_VALID deasserts in the cycle after the pop that drives rem to 0.
- Minimum spacing between SEND_REQUEST pulses is N + 4 cycles (IDLE, REQ, WAIT ≥1, XFER N, DONE ≥1).
- Full FIFO: DIN_READY=0 in the same cycle FIFO_COUNT=D. A pop in that cycle raises DIN_READY on the following cycle.

## Test plan
- **Basic datagram:** PKT_WORDS=4, write 0x11111111..0x44444444 with SEND_BUSY tied to follow REQUEST +1 → one SEND_REQUEST, SEND_LENGTH=16, data read in order, PKT_COUNT=1, FIFO_COUNT=0.
- **Flush:** PKT_WORDS=8, write 3 words, pulse FLUSH → SEND_LENGTH=12, exactly 3 words popped; FLUSH with an empty FIFO produces no request.
- **Full and back-pressure:** DEPTH_LOG2=4, hold SEND_BUSY=1, write 20 words → DIN_READY=0 after 16 accepted, FIFO_COUNT=16, no word lost or duplicated once released.
- **Streaming:** PKT_WORDS=256, continuous DIN and SEND_DATA_READ every cycle → 4 datagrams of length 1024, ramp data contiguous across boundaries, no gaps within XFER.
- **Clamp and zero:** PKT_WORDS=0 → length 4; PKT_WORDS=1023 with D=512 → length 2048.
- **Mid-transfer reset and wrap:** assert RST in XFER after 2 of 4 pops → all outputs at reset values, FIFO_COUNT=0; preset PKT_COUNT to 0xFFFF via 65535 datagrams (or forced) → next completion yields 0.
